hs_rx_unpacker: RTL and testbench



---
 rtl/hs_rx_pkg.sv | 21 ++
 rtl/hs_rx_unpacker_if.sv | 23 ++
 rtl/hs_rx_slot2.sv | 67 ++++++
 rtl/hs_rx_unpacker.sv | 101 ++++++++++
 tb/tb_hs_rx_unpacker.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hs_rx_pkg.sv
// rtl/hs_rx_pkg.sv - shared types and sizing constants for the hs_rx unpacker
package hs_rx_pkg;

    localparam int WIDTH_DEF       = 32;
    localparam int ELEM_W_DEF      = 8;
    localparam int FRAME_WORDS_DEF = 4;
    localparam int NUM_ELEM        = WIDTH_DEF / ELEM_W_DEF;
    localparam int IDX_W           = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam int FCNT_W          = (FRAME_WORDS_DEF > 1) ? $clog2(FRAME_WORDS_DEF) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // Counters for a single value still need one bit of storage.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/hs_rx_unpacker_if.sv
// rtl/hs_rx_unpacker_if.sv - word-in / element-stream-out bundle of the unpacker
interface hs_rx_unpacker_if #(
    parameter int WIDTH  = 32,
    parameter int ELEM_W = 8
);
    logic              dvalid;
    logic [WIDTH-1:0]  dout;
    logic              dbusy;
    logic              out_valid;
    logic [ELEM_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;

    modport slave (
        input  dvalid, dout, out_ready,
        output dbusy, out_valid, out_data, out_last
    );

    modport master (
        output dvalid, dout, out_ready,
        input  dbusy, out_valid, out_data, out_last
    );
endinterface

// File: rtl/hs_rx_slot2.sv
// rtl/hs_rx_slot2.sv - two-slot SHIFT/HOLD word buffer with accept and promote logic
module hs_rx_slot2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             retire_i,
    output logic [WIDTH-1:0] shift_data_o,
    output logic             hold_valid_o,
    output logic             drop_o
);
    logic             shift_valid_q, shift_valid_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             hold_valid_q, hold_valid_d;
    logic [WIDTH-1:0] hold_q, hold_d;

    always_comb begin
        shift_valid_d = shift_valid_q;
        shift_d       = shift_q;
        hold_valid_d  = hold_valid_q;
        hold_d        = hold_q;
        drop_o        = 1'b0;
        if (retire_i) begin
            // Retiring SHIFT: HOLD (if any) moves up, a new word refills behind it.
            if (hold_valid_q) begin
                shift_d       = hold_q;
                shift_valid_d = 1'b1;
                hold_valid_d  = in_valid_i;
                if (in_valid_i) hold_d = in_data_i;
            end else begin
                shift_valid_d = in_valid_i;
                if (in_valid_i) shift_d = in_data_i;
            end
        end else if (!shift_valid_q) begin
            if (in_valid_i) begin
                shift_valid_d = 1'b1;
                shift_d       = in_data_i;
            end
        end else if (in_valid_i) begin
            if (!hold_valid_q) begin
                hold_valid_d = 1'b1;
                hold_d       = in_data_i;
            end else begin
                drop_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_valid_q <= 1'b0;
            shift_q       <= '0;
            hold_valid_q  <= 1'b0;
            hold_q        <= '0;
        end else begin
            shift_valid_q <= shift_valid_d;
            shift_q       <= shift_d;
            hold_valid_q  <= hold_valid_d;
            hold_q        <= hold_d;
        end
    end

    assign shift_data_o = shift_q;
    assign hold_valid_o = hold_valid_q;
endmodule

// File: rtl/hs_rx_unpacker.sv
// rtl/hs_rx_unpacker.sv - unpacks synchronizer words into a framed element stream (option: HS_RX_OVF_CHECK_EN)
module hs_rx_unpacker
    import hs_rx_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int ELEM_W      = ELEM_W_DEF,
    parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    hs_rx_unpacker_if.slave bus
`ifdef HS_RX_OVF_CHECK_EN
    ,
    output logic ovf_err
`endif
);
    localparam int N_ELEM = WIDTH / ELEM_W;
    localparam int IW     = clog2_min1(N_ELEM);
    localparam int FW     = clog2_min1(FRAME_WORDS);

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic [WIDTH-1:0] shift_data;
    logic [WIDTH-1:0] shifted;
    logic             hold_valid;
    logic             drop;
    logic             out_valid;
    logic             hs;
    logic             last_elem;
    logic             retire;

    hs_rx_slot2 #(.WIDTH(WIDTH)) u_slot2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (bus.dvalid),
        .in_data_i    (bus.dout),
        .retire_i     (retire),
        .shift_data_o (shift_data),
        .hold_valid_o (hold_valid),
        .drop_o       (drop)
    );

    assign out_valid = (state_q == EMIT);
    assign hs        = out_valid && bus.out_ready;
    assign last_elem = (idx_q == IW'(N_ELEM - 1));
    assign retire    = hs && last_elem;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.dvalid) state_d = EMIT;
            EMIT:    if (retire && !hold_valid && !bus.dvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d  = idx_q;
        fcnt_d = fcnt_q;
        if (hs) begin
            if (last_elem) begin
                idx_d  = '0;
                fcnt_d = (fcnt_q == FW'(FRAME_WORDS - 1)) ? '0 : fcnt_q + 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // MSB-first: element idx is brought to the top of the word.
    assign shifted       = shift_data << (int'(idx_q) * ELEM_W);
    assign bus.out_data  = out_valid ? shifted[WIDTH-1 -: ELEM_W] : '0;
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_valid && last_elem && (fcnt_q == FW'(FRAME_WORDS - 1));
    assign bus.dbusy     = hold_valid;

`ifdef HS_RX_OVF_CHECK_EN
    logic ovf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_q | drop;
    end
    assign ovf_err = ovf_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif
endmodule

// File: tb/tb_hs_rx_unpacker.sv
// tb/tb_hs_rx_unpacker.sv - directed self-checking bench for hs_rx_unpacker
module tb_hs_rx_unpacker;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
`ifdef HS_RX_OVF_CHECK_EN
    logic ovf_err;
`endif

    hs_rx_unpacker_if #(.WIDTH(32), .ELEM_W(8)) bus ();

    hs_rx_unpacker #(.WIDTH(32), .ELEM_W(8), .FRAME_WORDS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef HS_RX_OVF_CHECK_EN
        ,
        .ovf_err (ovf_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.dvalid    = 1'b0;
        bus.dout      = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus.dbusy, bus.out_valid, bus.out_data, bus.out_last} !== 11'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", {bus.dbusy, bus.out_valid, bus.out_data, bus.out_last});
        end
`ifdef HS_RX_OVF_CHECK_EN
        checks++;
        if (ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got=%b exp=0", ovf_err);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [7:0] exp [4];
        exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        do_reset();
        bus.dout = 32'hA1B2C3D4;
        bus.dvalid = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.dvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus.out_valid, bus.out_data, bus.out_last} !== {1'b1, exp[i], 1'b0}) begin
                errors++;
                $display("FAIL single_e%0d got=v%b d%h l%b exp=v1 d%h l0", i, bus.out_valid, bus.out_data, bus.out_last, exp[i]);
            end
            tick();
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_frame();
        logic [31:0] words [4];
        int w;
        int e;
        bit started;
        words = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
        w = 0;
        e = 0;
        started = 0;
        do_reset();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (bus.out_valid) begin
                started = 1;
                checks++;
                if (bus.out_data !== e[7:0] || bus.out_last !== (e == 15)) begin
                    errors++;
                    $display("FAIL frame_e%0d got=d%h l%b exp=d%h l%b", e, bus.out_data, bus.out_last, e[7:0], (e == 15));
                end
                e++;
            end else if (started && e < 16) begin
                checks++;
                errors++;
                $display("FAIL frame_gap at element %0d got=0 exp=1", e);
            end
            if (w < 4 && !bus.dbusy) begin
                bus.dvalid = 1'b1;
                bus.dout = words[w];
                w++;
            end else begin
                bus.dvalid = 1'b0;
            end
            tick();
        end
        checks++;
        if (e != 16) begin
            errors++;
            $display("FAIL frame_count got=%0d exp=16", e);
        end
        // fcnt must have wrapped: the next word's last element is not a frame end
        bus.dout = 32'h10111213;
        bus.dvalid = 1'b1;
        tick();
        bus.dvalid = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_last} !== {1'b1, 8'h13, 1'b0}) begin
            errors++;
            $display("FAIL frame_wrap got=v%b d%h l%b exp=v1 d13 l0", bus.out_valid, bus.out_data, bus.out_last);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp [8];
        exp = '{{1'b0, 8'h11}, {1'b1, 8'h22}, {1'b1, 8'h33}, {1'b1, 8'h44},
                {1'b0, 8'h55}, {1'b0, 8'h66}, {1'b0, 8'h77}, {1'b0, 8'h88}};
        do_reset();
        bus.out_ready = 1'b1;
        bus.dout = 32'h11223344;
        bus.dvalid = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({bus.dbusy, bus.out_valid, bus.out_data} !== {exp[i][8], 1'b1, exp[i][7:0]}) begin
                errors++;
                $display("FAIL b2b_c%0d got=busy%b v%b d%h exp=busy%b v1 d%h", i, bus.dbusy, bus.out_valid, bus.out_data, exp[i][8], exp[i][7:0]);
            end
            if (i == 0) begin
                bus.dout = 32'h55667788;
                bus.dvalid = 1'b1;
            end else begin
                bus.dvalid = 1'b0;
            end
            tick();
        end
        checks++;
        if ({bus.dbusy, bus.out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_end got=%b exp=00", {bus.dbusy, bus.out_valid});
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp [5];
        logic       rdy [5];
        exp = '{8'hDE, 8'hAD, 8'hAD, 8'hAD, 8'hBE};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        bus.dout = 32'hDEADBEEF;
        bus.dvalid = 1'b1;
        tick();
        bus.dvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.out_valid, bus.out_data} !== {1'b1, exp[i]}) begin
                errors++;
                $display("FAIL stall_c%0d got=v%b d%h exp=v1 d%h", i, bus.out_valid, bus.out_data, exp[i]);
            end
            bus.out_ready = rdy[i];
            tick();
        end
        checks++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, 8'hEF}) begin
            errors++;
            $display("FAIL stall_last got=v%b d%h exp=v1 dEF", bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_overflow();
        logic [63:0] both;
        both = {32'h12345678, 32'h9ABCDEF0};
        do_reset();
        bus.dout = 32'h12345678;
        bus.dvalid = 1'b1;
        tick();
        bus.dout = 32'h9ABCDEF0;
        tick();
        checks++;
        if (bus.dbusy !== 1'b1) begin
            errors++;
            $display("FAIL ovf_busy got=%b exp=1", bus.dbusy);
        end
`ifdef HS_RX_OVF_CHECK_EN
        checks++;
        if (ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_early got=%b exp=0", ovf_err);
        end
`endif
        bus.dout = 32'hFFFFFFFF;
        tick();
        bus.dvalid = 1'b0;
`ifdef HS_RX_OVF_CHECK_EN
        checks++;
        if (ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got=%b exp=1", ovf_err);
        end
`endif
        tick();
        tick();
`ifdef HS_RX_OVF_CHECK_EN
        checks++;
        if (ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got=%b exp=1", ovf_err);
        end
`endif
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({bus.out_valid, bus.out_data} !== {1'b1, both[63 - 8*i -: 8]}) begin
                errors++;
                $display("FAIL ovf_e%0d got=v%b d%h exp=v1 d%h", i, bus.out_valid, bus.out_data, both[63 - 8*i -: 8]);
            end
            tick();
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drop got=v%b d%h exp=v0", bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.out_ready = 1'b1;
        bus.dout = 32'h01020304;
        bus.dvalid = 1'b1;
        tick();
        bus.dout = 32'h05060708;
        tick();
        bus.dvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.dbusy, bus.out_valid, bus.out_data, bus.out_last} !== 11'h0) begin
            errors++;
            $display("FAIL rstmid_outputs got=%h exp=0", {bus.dbusy, bus.out_valid, bus.out_data, bus.out_last});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.dbusy, bus.out_valid} !== 2'b00) begin
                errors++;
                $display("FAIL rstmid_idle%0d got=%b exp=00", i, {bus.dbusy, bus.out_valid});
            end
        end
        bus.dout = 32'hAABBCCDD;
        bus.dvalid = 1'b1;
        tick();
        bus.dvalid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, 8'hAA}) begin
            errors++;
            $display("FAIL rstmid_fresh got=v%b d%h exp=v1 dAA", bus.out_valid, bus.out_data);
        end
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        errors = 0;
        checks = 0;
        bus.dvalid = 1'b0;
        bus.dout = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_frame();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
